// File: rtl/spi_register_master.sv
// spi_register_master: SPI mode-0 initiator that shifts {register number, value} frames out on MOSI
// and captures MISO readback. Define SPI_MASTER_FIFO_EN to add a FIFO_DEPTH-entry command FIFO.

module spi_register_master #(
    parameter int CLK_DIV         = 4,
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 2,
    parameter int GAP_CYCLES      = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_WriteValid,
    output logic        o_WriteReady,
    input  logic [15:0] i_RegisterNumber,
    input  logic [15:0] i_RegisterValue,
    output logic        o_ReadValid,
    output logic [31:0] o_ReadData,
    output logic        o_Busy,
    output logic        o_SPI_CS,
    output logic        o_SPI_SCK,
    output logic        o_SPI_MOSI,
    input  logic        i_SPI_MISO
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam int PHASE_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES)
                             ? ((CS_SETUP_CYCLES > GAP_CYCLES) ? CS_SETUP_CYCLES : GAP_CYCLES)
                             : ((CS_HOLD_CYCLES > GAP_CYCLES) ? CS_HOLD_CYCLES : GAP_CYCLES);
    localparam int CNT_W = $clog2(PHASE_MAX + 1);
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYCLES - 1);
    // CS high time includes the IDLE cycle that accepts the next command.
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);

    state_t            state;
    logic [CNT_W-1:0]  phase_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        bit_cnt;
    logic [30:0]       tx_shift;
    logic [31:0]       capture;
    logic              miso_meta;
    logic              miso_sync;
    logic              ready;
    logic              start;
    logic [31:0]       start_word;

    assign o_WriteReady = ready;

`ifdef SPI_MASTER_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    logic [31:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;

    assign push       = i_WriteValid && ready;
    assign start      = (state == IDLE) && (count != '0);
    assign start_word = mem[rd_ptr];
    assign o_Busy     = (state != IDLE) || (count != '0);

    always_comb begin
        count_next = count;
        if (push && !start) begin
            count_next = count + (AW + 1)'(1);
        end else if (start && !push) begin
            count_next = count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= {i_RegisterNumber, i_RegisterValue};
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (start) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            ready <= (count_next != FULL_COUNT);
        end
    end
`else
    assign start      = (state == IDLE) && i_WriteValid && ready;
    assign start_word = {i_RegisterNumber, i_RegisterValue};
    assign o_Busy     = (state != IDLE);
`endif

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= i_SPI_MISO;
            miso_sync <= miso_meta;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            capture     <= '0;
            o_SPI_CS    <= 1'b1;
            o_SPI_SCK   <= 1'b0;
            o_SPI_MOSI  <= 1'b0;
            o_ReadValid <= 1'b0;
            o_ReadData  <= '0;
`ifndef SPI_MASTER_FIFO_EN
            ready       <= 1'b0;
`endif
        end else begin
            o_ReadValid <= 1'b0;
            case (state)
                IDLE: begin
`ifndef SPI_MASTER_FIFO_EN
                    ready <= !start;
`endif
                    if (start) begin
                        tx_shift   <= start_word[30:0];
                        o_SPI_MOSI <= start_word[31];
                        o_SPI_CS   <= 1'b0;
                        capture    <= '0;
                        phase_cnt  <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_cnt == SETUP_LAST) begin
                        phase_cnt <= '0;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        o_SPI_SCK <= !o_SPI_SCK;
                        if (!o_SPI_SCK) begin
                            capture <= {capture[30:0], miso_sync};
                        end else if (bit_cnt == 5'd31) begin
                            phase_cnt <= '0;
                            state     <= HOLD;
                        end else begin
                            bit_cnt    <= bit_cnt + 5'd1;
                            o_SPI_MOSI <= tx_shift[30];
                            tx_shift   <= {tx_shift[29:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        o_SPI_CS    <= 1'b1;
                        o_SPI_MOSI  <= 1'b0;
                        o_ReadData  <= capture;
                        o_ReadValid <= 1'b1;
                        phase_cnt   <= '0;
                        if (GAP_CYCLES > 1) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
`ifndef SPI_MASTER_FIFO_EN
                            ready <= 1'b1;
`endif
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        phase_cnt <= '0;
                        state     <= IDLE;
`ifndef SPI_MASTER_FIFO_EN
                        ready     <= 1'b1;
`endif
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_register_master.sv
// tb_spi_register_master: directed bench for spi_register_master with a mode-0 SPI slave model
// and a monitor for SCK idle level and MOSI/SCK timing.

module tb_spi_register_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] num = '0;
    logic [15:0] val = '0;
    logic        ready;
    logic        rv;
    logic [31:0] rd;
    logic        busy;
    logic        cs;
    logic        sck;
    logic        mosi;
    logic        miso = 1'b0;

`ifdef SPI_MASTER_FIFO_EN
    localparam int  PIPE  = 1;
    localparam bit  HOLD1 = 1'b0;
`else
    localparam int  PIPE  = 0;
    localparam bit  HOLD1 = 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    spi_register_master #(
        .CLK_DIV(4),
        .CS_SETUP_CYCLES(2),
        .CS_HOLD_CYCLES(2),
        .GAP_CYCLES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .i_Clock(clk),
        .i_Reset_n(rst_n),
        .i_WriteValid(valid),
        .o_WriteReady(ready),
        .i_RegisterNumber(num),
        .i_RegisterValue(val),
        .o_ReadValid(rv),
        .o_ReadData(rd),
        .o_Busy(busy),
        .o_SPI_CS(cs),
        .o_SPI_SCK(sck),
        .o_SPI_MOSI(mosi),
        .i_SPI_MISO(miso)
    );

    always #5 clk = ~clk;

    // Mode-0 slave: MISO leads on CS fall and shifts on SCK fall; MOSI is sampled on SCK rise.
    logic [31:0] slave_pattern = 32'h0;
    logic [31:0] s_tx = '0;
    logic [31:0] s_rx = '0;
    int          s_bits = 0;
    int          last_bits = 0;
    int          nframes = 0;
    logic [31:0] frames [16];
    logic        cs_prev = 1'b1;
    logic        sck_prev = 1'b0;

    always @(cs, sck) begin
        if (cs_prev === 1'b1 && cs === 1'b0) begin
            s_tx   = slave_pattern;
            s_rx   = '0;
            s_bits = 0;
            miso   = slave_pattern[31];
        end
        if (cs === 1'b0 && sck_prev === 1'b0 && sck === 1'b1) begin
            s_rx   = {s_rx[30:0], mosi};
            s_bits = s_bits + 1;
        end
        if (cs === 1'b0 && sck_prev === 1'b1 && sck === 1'b0) begin
            s_tx = {s_tx[30:0], 1'b0};
            miso = s_tx[31];
        end
        if (cs_prev === 1'b0 && cs === 1'b1) begin
            last_bits = s_bits;
            if (s_bits == 32) begin
                if (nframes < 16) frames[nframes] = s_rx;
                nframes = nframes + 1;
            end
        end
        cs_prev  = cs;
        sck_prev = sck;
    end

    int   cyc = 0;
    int   last_rise = -100;
    int   last_chg = -100;
    int   mode_viol = 0;
    int   idle_viol = 0;
    int   cs_low_cycles = 0;
    logic sck_q = 1'b0;
    logic mosi_q = 1'b0;

    always @(negedge clk) begin
        bit rise_now;
        bit chg_now;
        cyc = cyc + 1;
        if (cs === 1'b0) cs_low_cycles = cs_low_cycles + 1;
        if (rst_n) begin
            rise_now = (sck === 1'b1) && (sck_q === 1'b0);
            chg_now  = (mosi !== mosi_q);
            if (rise_now && (chg_now || (cyc - last_chg <= 1))) mode_viol = mode_viol + 1;
            if (chg_now && (cyc - last_rise <= 1)) mode_viol = mode_viol + 1;
            if (rise_now) last_rise = cyc;
            if (chg_now) last_chg = cyc;
            if (cs === 1'b1 && sck !== 1'b0) idle_viol = idle_viol + 1;
        end
        sck_q  = sck;
        mosi_q = mosi;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h (%0d) expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
        end
    endtask

    // Returns just after the accepting posedge; valid stays high when hold is set.
    task automatic send(input logic [15:0] n, input logic [15:0] v, input bit hold);
        int t;
        valid = 1'b1;
        num   = n;
        val   = v;
        t = 0;
        while (ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) valid = 1'b0;
    endtask

    initial begin
        int k;
        int g;
        int t;
        int base;
        int c0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_sck", {31'd0, sck}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_rv", {31'd0, rv}, 32'd0);
        check("rst_rd", rd, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", {31'd0, ready}, 32'd1);
        @(negedge clk);

        // Single write with readback; valid held a few cycles while busy
        slave_pattern = 32'hA5A55A5A;
        base = nframes;
        c0   = cs_low_cycles;
        send(16'hC012, 16'h00F0, HOLD1);
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1 + PIPE) begin
                check("cs_fall_latency", {31'd0, cs}, 32'd0);
                check("busy_in_frame", {31'd0, busy}, 32'd1);
            end
            if (k == 10) valid = 1'b0;
            if (rv === 1'b1) break;
        end
        valid = 1'b0;
        check("rv_latency", k, 32'(261 + PIPE));
        check("read_data", rd, 32'hA5A55A5A);
        check("cs_high_at_rv", {31'd0, cs}, 32'd1);
        @(negedge clk);
        check("rv_one_pulse", {31'd0, rv}, 32'd0);
        check("cs_low_clocks", 32'(cs_low_cycles - c0), 32'd260);
        check("sck_rises", 32'(last_bits), 32'd32);
        check("slave_word", frames[base], 32'hC01200F0);
        repeat (20) @(negedge clk);
        check("single_frame_count", 32'(nframes - base), 32'd1);

        // Back-to-back with valid held
        slave_pattern = 32'h0F0F3C3C;
        base = nframes;
        send(16'h8001, 16'h1234, 1'b1);
        num = 16'h8002;
        val = 16'h5678;
`ifdef SPI_MASTER_FIFO_EN
        @(posedge clk);
        #1 valid = 1'b0;
`endif
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (cs === 1'b0 && t < 400);
        g = 0;
        while (cs === 1'b1 && g < 50) begin
            g++;
            @(negedge clk);
        end
        valid = 1'b0;
        check("gap_clocks", g, 32'd4);
        repeat (700) @(negedge clk);
        check("b2b_frame_count", 32'(nframes - base), 32'd2);
        check("b2b_word0", frames[base], 32'h80011234);
        check("b2b_word1", frames[base + 1], 32'h80025678);
        check("b2b_readback", rd, 32'h0F0F3C3C);

`ifdef SPI_MASTER_FIFO_EN
        // Five queued commands emitted in order
        base = nframes;
        for (int i = 0; i < 5; i++) begin
            send(16'(16'h9000 + i), 16'(16'h0100 * (i + 1)), 1'b0);
        end
        repeat (1600) @(negedge clk);
        check("fifo_frame_count", 32'(nframes - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("fifo_word", frames[base + i], {16'(16'h9000 + i), 16'(16'h0100 * (i + 1))});
        end
`endif

        check("mosi_near_sck_rise", 32'(mode_viol), 32'd0);
        check("sck_idle_low", 32'(idle_viol), 32'd0);

        // Reset in the middle of SHIFT with SCK high and MOSI high
        slave_pattern = 32'h0;
        base = nframes;
        send(16'hFFFF, 16'hFFFF, 1'b0);
        repeat (40) @(negedge clk);
        t = 0;
        while (sck !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("pre_rst_sck", {31'd0, sck}, 32'd1);
        check("pre_rst_mosi", {31'd0, mosi}, 32'd1);
        check("pre_rst_cs", {31'd0, cs}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cs", {31'd0, cs}, 32'd1);
        check("midrst_sck", {31'd0, sck}, 32'd0);
        check("midrst_mosi", {31'd0, mosi}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready_release", {31'd0, ready}, 32'd1);
        c0 = cs_low_cycles;
        repeat (300) @(negedge clk);
        check("no_resume_cs", 32'(cs_low_cycles - c0), 32'd0);
        check("no_resume_frames", 32'(nframes - base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
